prbs9_ber_checker: RTL and testbench

Bit-error-rate checker that sits directly downstream of the `prbs9` generator, at the receive end of the QPSK link or in loopback. It self-synchronises a local PRBS9 replica (x^9 + x^5 + 1) to the incoming bit stream and declares lock. Once locked, it counts received bits and bit errors in saturating counters that a host or VIO can read.

---
 rtl/prbs_pkg.sv | 13 +
 rtl/prbs9_ber_checker_sat_counter.sv | 31 +++
 rtl/prbs9_ber_checker.sv | 165 ++++++++++++++++
 tb/tb_prbs9_ber_checker.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/prbs_pkg.sv
// Constants and FSM state type shared by the PRBS9 generator and BER checker.
package prbs_pkg;

   localparam int PRBS9_LEN = 9;
   localparam int PRBS9_TAP = 4;

   typedef enum logic [1:0] {
      LOAD,
      VERIFY,
      LOCKED
   } ber_state_t;

endpackage

// File: rtl/prbs9_ber_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             increment,
   input  logic             clear,
   output logic [WIDTH-1:0] value
);

   logic [WIDTH-1:0] value_q, value_d;

   always_comb begin
      value_d = value_q;
      if (clear)
         value_d = '0;
      else if (increment && (value_q != '1))
         value_d = value_q + WIDTH'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst)
         value_q <= '0;
      else
         value_q <= value_d;
   end

   assign value = value_q;

endmodule

// File: rtl/prbs9_ber_checker.sv
// Self-synchronising PRBS9 (x^9 + x^5 + 1) BER checker with saturating counters.
// Define PRBS9_BER_LOS_EN to compile in windowed loss-of-sync detection.
module prbs9_ber_checker
   import prbs_pkg::*;
#(
   parameter int NB_CNT     = 32,
   parameter int LOCK_BITS  = 32,
   parameter int LOS_WINDOW = 256,
   parameter int LOS_THRESH = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_enable,
   input  logic              i_bit,
   input  logic              i_clear,
   output logic              o_lock,
   output logic              o_err,
   output logic [NB_CNT-1:0] o_bit_cnt,
   output logic [NB_CNT-1:0] o_err_cnt
);

   localparam int MW = $clog2(LOCK_BITS + 1);
   localparam int LW = $clog2(PRBS9_LEN);

   if (LOCK_BITS < 1 || LOS_WINDOW < 1 || LOS_THRESH < 1) begin : g_bad_cfg
      $error("prbs9_ber_checker: LOCK_BITS, LOS_WINDOW and LOS_THRESH must be >= 1");
   end

   ber_state_t           state_q, state_d;
   logic [PRBS9_LEN-1:0] sr_q, sr_d;
   logic [LW-1:0]        load_cnt_q, load_cnt_d;
   logic [MW-1:0]        match_cnt_q, match_cnt_d, match_nxt;
   logic                 lock_q, lock_d;
   logic                 err_q, err_d;
   logic                 pred, bit_inc, err_inc;

`ifdef PRBS9_BER_LOS_EN
   localparam int WW = $clog2(LOS_WINDOW + 1);
   localparam int TW = $clog2(LOS_THRESH + 1);
   logic [WW-1:0] win_cnt_q, win_cnt_d, win_nxt;
   logic [TW-1:0] los_err_q, los_err_d, los_nxt;
`endif

   assign pred      = sr_q[PRBS9_LEN-1] ^ sr_q[PRBS9_TAP];
   assign match_nxt = match_cnt_q + MW'(1);

   always_comb begin
      state_d     = state_q;
      sr_d        = sr_q;
      load_cnt_d  = load_cnt_q;
      match_cnt_d = match_cnt_q;
      lock_d      = lock_q;
      err_d       = 1'b0;
      bit_inc     = 1'b0;
      err_inc     = 1'b0;
`ifdef PRBS9_BER_LOS_EN
      win_cnt_d   = win_cnt_q;
      los_err_d   = los_err_q;
      win_nxt     = win_cnt_q + WW'(1);
      los_nxt     = los_err_q + TW'(1);
`endif
      if (i_enable) begin
         case (state_q)
            LOAD: begin
               sr_d = {sr_q[PRBS9_LEN-2:0], i_bit};
               if (load_cnt_q == LW'(PRBS9_LEN - 1)) begin
                  state_d     = VERIFY;
                  match_cnt_d = '0;
               end else begin
                  load_cnt_d = load_cnt_q + LW'(1);
               end
            end
            VERIFY: begin
               sr_d = {sr_q[PRBS9_LEN-2:0], i_bit};
               // An all-zero register predicts zero forever; never trust it.
               if ((i_bit == pred) && (sr_q != '0)) begin
                  if (match_nxt == MW'(LOCK_BITS)) begin
                     state_d     = LOCKED;
                     lock_d      = 1'b1;
                     match_cnt_d = '0;
`ifdef PRBS9_BER_LOS_EN
                     win_cnt_d   = '0;
                     los_err_d   = '0;
`endif
                  end else begin
                     match_cnt_d = match_nxt;
                  end
               end else begin
                  match_cnt_d = '0;
               end
            end
            LOCKED: begin
               // Free-run on the prediction so a line error is counted once.
               sr_d    = {sr_q[PRBS9_LEN-2:0], pred};
               bit_inc = 1'b1;
               err_d   = (i_bit != pred);
               err_inc = err_d;
`ifdef PRBS9_BER_LOS_EN
               if (err_d && (los_nxt == TW'(LOS_THRESH))) begin
                  state_d     = VERIFY;
                  lock_d      = 1'b0;
                  match_cnt_d = '0;
                  win_cnt_d   = '0;
                  los_err_d   = '0;
               end else if (win_nxt == WW'(LOS_WINDOW)) begin
                  win_cnt_d = '0;
                  los_err_d = '0;
               end else begin
                  win_cnt_d = win_nxt;
                  if (err_d)
                     los_err_d = los_nxt;
               end
`endif
            end
            default: state_d = LOAD;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= LOAD;
         sr_q        <= '0;
         load_cnt_q  <= '0;
         match_cnt_q <= '0;
         lock_q      <= 1'b0;
         err_q       <= 1'b0;
`ifdef PRBS9_BER_LOS_EN
         win_cnt_q   <= '0;
         los_err_q   <= '0;
`endif
      end else begin
         state_q     <= state_d;
         sr_q        <= sr_d;
         load_cnt_q  <= load_cnt_d;
         match_cnt_q <= match_cnt_d;
         lock_q      <= lock_d;
         err_q       <= err_d;
`ifdef PRBS9_BER_LOS_EN
         win_cnt_q   <= win_cnt_d;
         los_err_q   <= los_err_d;
`endif
      end
   end

   sat_counter #(.WIDTH(NB_CNT)) u_bit_cnt (
      .clk       (clk),
      .rst       (rst),
      .increment (bit_inc),
      .clear     (i_clear),
      .value     (o_bit_cnt)
   );

   sat_counter #(.WIDTH(NB_CNT)) u_err_cnt (
      .clk       (clk),
      .rst       (rst),
      .increment (err_inc),
      .clear     (i_clear),
      .value     (o_err_cnt)
   );

   assign o_lock = lock_q;
   assign o_err  = err_q;

endmodule

// File: tb/tb_prbs9_ber_checker.sv
// Directed bench for prbs9_ber_checker: a sequence-level reference model checked
// every cycle, plus literal expectations; a 4-bit-counter instance covers saturation.
module tb_prbs9_ber_checker;

   localparam int LOCK_BITS = 32;
   localparam int LOS_WIN   = 256;
   localparam int LOS_THR   = 16;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic i_enable = 1'b0, i_bit = 1'b0, i_clear = 1'b0;

   logic        lock_a, err_a, lock_b, err_b;
   logic [31:0] bitc_a, errc_a;
   logic [3:0]  bitc_b, errc_b;

   always #5 clk = ~clk;

   prbs9_ber_checker #(.NB_CNT(32), .LOCK_BITS(LOCK_BITS), .LOS_WINDOW(LOS_WIN), .LOS_THRESH(LOS_THR)) dut_a (
      .clk(clk), .rst(rst), .i_enable(i_enable), .i_bit(i_bit), .i_clear(i_clear),
      .o_lock(lock_a), .o_err(err_a), .o_bit_cnt(bitc_a), .o_err_cnt(errc_a));

   prbs9_ber_checker #(.NB_CNT(4), .LOCK_BITS(LOCK_BITS), .LOS_WINDOW(LOS_WIN), .LOS_THRESH(LOS_THR)) dut_b (
      .clk(clk), .rst(rst), .i_enable(i_enable), .i_bit(i_bit), .i_clear(i_clear),
      .o_lock(lock_b), .o_err(err_b), .o_bit_cnt(bitc_b), .o_err_cnt(errc_b));

   int n_cmp = 0;
   int n_bad = 0;
   int n_pulse = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: the last nine reference bits (oldest first). Before lock they
   // are the received bits; once locked they are the regenerated sequence.
   bit     ref9[$];
   int     m_seen, m_run, m_win, m_werr;
   bit     m_lock, m_err, m_init = 1'b0;
   longint m_bitc, m_errc, m_bitc4, m_errc4;

   function automatic longint sat_inc(input longint v, input longint maxv);
      return (v < maxv) ? v + 1 : maxv;
   endfunction

   always @(posedge clk) begin
      bit exp_b, all_zero, bad;
      if (!rst) begin
         ref9 = {};
         for (int i = 0; i < 9; i++) ref9.push_back(1'b0);
         m_seen = 0; m_run = 0; m_win = 0; m_werr = 0;
         m_lock = 0; m_err = 0; m_init = 1;
         m_bitc = 0; m_errc = 0; m_bitc4 = 0; m_errc4 = 0;
      end else begin
         m_err = 0;
         if (i_enable) begin
            exp_b = ref9[0] ^ ref9[4];
            all_zero = 1;
            foreach (ref9[i]) if (ref9[i]) all_zero = 0;
            if (m_lock) begin
               bad = (i_bit != exp_b);
               m_err = bad;
               m_bitc  = sat_inc(m_bitc, 64'hFFFF_FFFF);
               m_bitc4 = sat_inc(m_bitc4, 15);
               if (bad) begin
                  m_errc  = sat_inc(m_errc, 64'hFFFF_FFFF);
                  m_errc4 = sat_inc(m_errc4, 15);
               end
               ref9.push_back(exp_b);
`ifdef PRBS9_BER_LOS_EN
               m_win++;
               if (bad) m_werr++;
               if (bad && m_werr == LOS_THR) begin
                  m_lock = 0; m_run = 0; m_win = 0; m_werr = 0;
               end else if (m_win == LOS_WIN) begin
                  m_win = 0; m_werr = 0;
               end
`endif
            end else begin
               if (m_seen >= 9) begin
                  if (i_bit == exp_b && !all_zero) m_run++;
                  else m_run = 0;
               end
               m_seen++;
               ref9.push_back(i_bit);
               if (m_run == LOCK_BITS) begin
                  m_lock = 1; m_run = 0; m_win = 0; m_werr = 0;
               end
            end
            void'(ref9.pop_front());
         end
         if (i_clear) begin
            m_bitc = 0; m_errc = 0; m_bitc4 = 0; m_errc4 = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (m_init) begin
         chk("lock_a", lock_a, m_lock);
         chk("err_a", err_a, m_err);
         chk("bitc_a", bitc_a, m_bitc);
         chk("errc_a", errc_a, m_errc);
         chk("lock_b", lock_b, m_lock);
         chk("err_b", err_b, m_err);
         chk("bitc_b", bitc_b, m_bitc4);
         chk("errc_b", errc_b, m_errc4);
         if (err_a === 1'b1) n_pulse++;
      end
   end

   // Stimulus PRBS9 source: b[n] = b[n-9] ^ b[n-5].
   localparam logic [8:0] SEED = 9'b010101011;
   logic [8:0] g;

   task automatic next_bit(output logic b);
      b = g[8] ^ g[4];
      g = {g[7:0], b};
   endtask

   task automatic tick(input logic en, input logic b, input logic clr);
      i_enable = en; i_bit = b; i_clear = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int n);
      logic b;
      for (int i = 0; i < n; i++) begin
         next_bit(b);
         tick(1'b1, b, 1'b0);
      end
   endtask

   task automatic send_flip(input logic clr);
      logic b;
      next_bit(b);
      tick(1'b1, ~b, clr);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      tick(1'b0, 1'b0, 1'b0);
      tick(1'b1, 1'b1, 1'b1);
      rst = 1'b1;
      g = SEED;
   endtask

   initial begin
      int p0;
      logic b;
      g = SEED;

      // Reset state and clean lock on the 41st bit.
      do_reset();
      chk("rst_lock", lock_a, 0);
      chk("rst_err", err_a, 0);
      chk("rst_bitc", bitc_a, 0);
      chk("rst_errc", errc_a, 0);
      send(40);
      chk("lock_at_40", lock_a, 0);
      send(1);
      chk("lock_at_41", lock_a, 1);
      chk("lock_bit_uncounted", bitc_a, 0);
      send(1000);
      chk("bitc_1000", bitc_a, 1000);
      chk("errc_clean", errc_a, 0);
      chk("bitc4_sat", bitc_b, 15);

      // Single flipped bit.
      p0 = n_pulse;
      send_flip(1'b0);
      chk("flip_err_pulse", err_a, 1);
      send(50);
      chk("flip_errc", errc_a, 1);
      chk("flip_lock", lock_a, 1);
      chk("flip_pulses", n_pulse - p0, 1);
      chk("flip_bitc", bitc_a, 1051);

      // Clear wins over an enabled errored bit; then 4-bit saturation again.
      send_flip(1'b1);
      chk("clr_bitc", bitc_a, 0);
      chk("clr_errc", errc_a, 0);
      chk("clr_errc4", errc_b, 0);
      send(5);
      chk("post_clr_bitc", bitc_a, 5);
      send(20);
      chk("sat4_20", bitc_b, 15);

      // Stuck line never locks.
      do_reset();
      for (int i = 0; i < 200; i++) tick(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 200; i++) tick(1'b1, 1'b1, 1'b0);
      chk("stuck_lock", lock_a, 0);
      chk("stuck_bitc", bitc_a, 0);
      chk("stuck_errc", errc_a, 0);

      // Gated input: same lock point in bit units; junk on disabled cycles.
      do_reset();
      for (int i = 0; i < 40; i++) begin
         send(1);
         tick(1'b0, 1'($urandom_range(0, 1)), 1'b0);
      end
      chk("gated_lock_40", lock_a, 0);
      send(1);
      chk("gated_lock_41", lock_a, 1);
      for (int i = 0; i < 10; i++) begin
         send(1);
         tick(1'b0, 1'($urandom_range(0, 1)), 1'b0);
      end
      chk("gated_bitc", bitc_a, 10);

      // One-cycle reset mid-lock, then a full relock from LOAD.
      rst = 1'b0;
      next_bit(b);
      tick(1'b1, b, 1'b0);
      rst = 1'b1;
      chk("midrst_lock", lock_a, 0);
      chk("midrst_err", err_a, 0);
      chk("midrst_bitc", bitc_a, 0);
      chk("midrst_errc", errc_a, 0);
      send(40);
      chk("relock_40", lock_a, 0);
      send(1);
      chk("relock_41", lock_a, 1);

      // Every 8th bit inverted after lock.
      do_reset();
      send(41);
      chk("los_pre_lock", lock_a, 1);
      for (int k = 0; k < 15; k++) begin
         send(7);
         send_flip(1'b0);
      end
      chk("los_15_errs", lock_a, 1);
      send(7);
      send_flip(1'b0);
      chk("los_errc16", errc_a, 16);
      chk("los_bitc128", bitc_a, 128);
`ifdef PRBS9_BER_LOS_EN
      chk("los_drop", lock_a, 0);
      send(31);
      chk("los_relock_31", lock_a, 0);
      send(1);
      chk("los_relock_32", lock_a, 1);
      chk("los_keep_bitc", bitc_a, 128);
      chk("los_keep_errc", errc_a, 16);
`else
      chk("no_los_hold", lock_a, 1);
      send(32);
      chk("no_los_bitc", bitc_a, 160);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
